// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: register ids, FSM states
// and the bundle of per-latch control bits with a few canned patterns.
package pipeline_hazard_ctrl_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

    localparam int DRAIN_W = 3;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_FREEZE = '{default: 1'b0};

    localparam hazard_ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Drain keeps MEM/WB retiring while everything younger becomes bubbles.
    localparam hazard_ctrl_t CTRL_DRAIN = '{
        pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath-facing bundle of the hazard sequencer: hazard sources in,
// latch/PC controls and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             dREN;
    logic             dWEN;
    regbits_t         IDrs;
    regbits_t         IDrt;
    regbits_t         EXwsel;
    logic             EXMemRd;
    logic             EXRegWr;
    logic             branch_taken;
    logic             jump;
    logic             MEMhalt;

    logic             pc_en;
    logic             IFID_en;
    logic             IDEX_en;
    logic             EXMEM_en;
    logic             MEMWB_en;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             EXMEM_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hc (
        input  ihit, dhit, dREN, dWEN, IDrs, IDrt, EXwsel, EXMemRd, EXRegWr,
               branch_taken, jump, MEMhalt,
        output pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, EXMEM_flush, halt, stall_cnt, flush_cnt
    );

    modport hctb (
        output ihit, dhit, dREN, dWEN, IDrs, IDrt, EXwsel, EXMemRd, EXRegWr,
               branch_taken, jump, MEMhalt,
        input  pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, EXMEM_flush, halt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating up-counter for the hazard statistics; sticks at all-ones
// rather than wrapping so long runs never under-report.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves the hazards the
// forwarding unit cannot, drains the pipe on halt and counts lost cycles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipeline_hazard_ctrl_if.hc    hif
);

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

    hazard_state_t      state;
    hazard_state_t      next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] next_drain;
    logic               halt_q;
    hazard_ctrl_t       ctrl;
    logic               stall_inc;
    logic               flush_inc;
    logic               mem_busy;
    logic               load_use;

    assign mem_busy = (hif.dREN | hif.dWEN) & ~hif.dhit;
    assign load_use = hif.EXMemRd & hif.EXRegWr & (hif.EXwsel != '0) &
                      ((hif.EXwsel == hif.IDrs) | (hif.EXwsel == hif.IDrt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt_q    <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain;
            if (next_state == HALTED) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_drain = drain_cnt;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    next_state = DWAIT;
                end else if (hif.MEMhalt) begin
                    next_state = DRAIN;
                    next_drain = DRAIN_INIT;
                end
            end
            DWAIT: begin
                if (hif.dhit) begin
                    next_state = RUN;
                end
            end
            DRAIN: begin
                // An outstanding data access freezes the countdown too.
                if (!mem_busy) begin
                    if (drain_cnt == '0) begin
                        next_state = HALTED;
                    end else begin
                        next_drain = drain_cnt - DRAIN_W'(1);
                    end
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        ctrl      = CTRL_FREEZE;
        flush_inc = 1'b0;
        if (nRST) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        ctrl = CTRL_FREEZE;
                    end else if (hif.MEMhalt) begin
                        ctrl = CTRL_DRAIN;
                    end else if (hif.branch_taken) begin
                        // A jump in ID is younger than the branch, so it is squashed too.
                        ctrl            = CTRL_ADVANCE;
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                        flush_inc       = 1'b1;
                    end else if (hif.jump) begin
                        ctrl            = CTRL_ADVANCE;
                        ctrl.ifid_flush = 1'b1;
                        flush_inc       = 1'b1;
                    end else if (load_use) begin
                        ctrl            = CTRL_ADVANCE;
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (!hif.ihit) begin
                        ctrl            = CTRL_ADVANCE;
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end
                DWAIT: begin
                    if (hif.dhit) begin
                        ctrl       = CTRL_ADVANCE;
                        ctrl.pc_en = hif.ihit;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        ctrl = CTRL_DRAIN;
                    end
                end
                default: ctrl = CTRL_FREEZE;
            endcase
        end
        stall_inc = nRST & ((state == RUN) | (state == DWAIT)) & ~ctrl.pc_en;
    end

    assign hif.pc_en       = ctrl.pc_en;
    assign hif.IFID_en     = ctrl.ifid_en;
    assign hif.IDEX_en     = ctrl.idex_en;
    assign hif.EXMEM_en    = ctrl.exmem_en;
    assign hif.MEMWB_en    = ctrl.memwb_en;
    assign hif.IFID_flush  = ctrl.ifid_flush;
    assign hif.IDEX_flush  = ctrl.idex_flush;
    assign hif.EXMEM_flush = ctrl.exmem_flush;
    assign hif.halt        = halt_q;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (hif.stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .count (hif.flush_cnt)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It takes hazard sources from the datapath: cache hits, load-use in ID/EX, taken branch in EX, jump in ID, and halt in MEM. From these it drives per-latch enable/flush controls and the PC enable. It also sequences the end-of-program drain and halt, and keeps saturating performance counters. It sits beside the forwarding unit and covers only the hazards forwarding cannot resolve.

Parameters:
DRAIN_CYCLES, 2, cycles MEM/WB stays enabled after halt detection so the halt and older instructions retire (1..7)
CNT_W, 32, width of stall/flush performance counters

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  icache returned the instruction this cycle
dhit  input  1  dcache completed the MEM-stage access this cycle
dREN  input  1  MEM-stage load request
dWEN  input  1  MEM-stage store request
IDrs  input  5  regbits_t, rs of the instruction in ID
IDrt  input  5  regbits_t, rt of the instruction in ID
EXwsel  input  5  regbits_t, destination of the instruction in EX
EXMemRd  input  1  instruction in EX is a load
EXRegWr  input  1  instruction in EX writes the register file
branch_taken  input  1  branch resolved taken in EX
jump  input  1  J/JAL/JR decoded in ID
MEMhalt  input  1  halt instruction in MEM
pc_en  output  1  PC register load enable
IFID_en, IDEX_en, EXMEM_en, MEMWB_en  output  1 each  latch enables
IFID_flush, IDEX_flush, EXMEM_flush  output  1 each  synchronous bubble insert, qualified by the matching enable
halt  output  1  sticky, program halted
stall_cnt  output  CNT_W  cycles with pc_en=0 in RUN or DWAIT
flush_cnt  output  CNT_W  redirects (branch_taken or jump accepted)

Behaviour:
- Derived signals:
  - mem_busy = (dREN|dWEN) & ~dhit
  - load_use = EXMemRd & EXRegWr & (EXwsel!=0) & (EXwsel==IDrs | EXwsel==IDrt)
- States: RUN, DWAIT, DRAIN, HALTED. Reset state is RUN.
- Register reset values: drain_cnt=0, halt=0, stall_cnt=0, flush_cnt=0.
- While nRST=0, all enables, all flushes and pc_en are 0.
- Outputs are combinational on the current state and inputs. State and counters update on the CLK rising edge.
- RUN controls, highest priority first:
  1. mem_busy: all enables 0, pc_en=0, next state DWAIT.
  2. MEMhalt: next state DRAIN; this cycle apply the DRAIN outputs; drain_cnt<=DRAIN_CYCLES-1.
  3. branch_taken: all enables 1, IFID_flush=1, IDEX_flush=1, pc_en=1 regardless of ihit; flush_cnt+1.
  4. jump: all enables 1, IFID_flush=1, pc_en=1; flush_cnt+1.
  5. load_use: pc_en=0, IFID_en=0, IDEX_en=1 with IDEX_flush=1, EXMEM_en=1, MEMWB_en=1. This gives exactly one bubble, because EX advances next cycle and clears the condition.
  6. ~ihit: pc_en=0, IFID_en=1 with IFID_flush=1, other enables 1.
  7. Otherwise: all enables 1, pc_en=1, no flush.
- branch_taken with jump in the same cycle: the branch wins and the jump in ID is flushed. flush_cnt increments by 1 only.
- DWAIT:
  - While ~dhit: all enables 0, pc_en=0.
  - On dhit: all enables 1, pc_en=ihit, next state RUN.
  - Load-use and branch are not evaluated in the dhit cycle; they are re-evaluated in RUN next cycle with the pipeline advanced.
- DRAIN:
  - Outputs: pc_en=0; IFID/IDEX/EXMEM flushed with enable 1; MEMWB_en=1.
  - drain_cnt decrements each cycle. At 0, next state HALTED.
  - mem_busy in DRAIN freezes everything without decrementing.
- HALTED: all enables 0, pc_en=0, halt=1. Exits only through reset.
- stall_cnt increments in any RUN/DWAIT cycle with pc_en=0, including the mem_busy entry cycle.
- Both counters saturate at all-ones and never wrap.
- Asynchronous reset mid-DWAIT or mid-DRAIN returns to RUN with counters cleared.

Decomposition:
- Add to cpu_types_pkg: hazard_state_t (2-bit enum RUN=0, DWAIT=1, DRAIN=2, HALTED=3).
- Add a pipeline_hazard_ctrl_if interface with modports hc (block) and hctb (bench).
- One sub-module, hazard_perf_counter: CNT_W saturating up-counter with inc input, instantiated twice.

Test Plan:
- Load-use: EX lw with EXwsel=8, ID add with IDrs=8, ihit=1 -> one cycle of pc_en=0, IFID_en=0, IDEX_flush=1; stall_cnt 0->1; with EXwsel=0 -> no stall.
- Dcache miss: dREN=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state DWAIT; all enables 1 in the dhit cycle; stall_cnt=3 (entry cycle plus 2 DWAIT cycles); RUN next cycle.
- Branch plus jump same cycle, ihit=0 -> pc_en=1, IFID_flush=1, IDEX_flush=1, flush_cnt +1 only.
- Halt with DRAIN_CYCLES=2 -> MEMWB_en=1 for exactly 2 cycles, then halt=1 and all enables 0 indefinitely.
- Halt while dREN=1, dhit=0 -> freeze in DWAIT first; DRAIN starts after dhit.
- Saturation with CNT_W=4: 20 stall cycles -> stall_cnt holds 15; nRST pulse mid-DRAIN -> RUN, halt=0, counters 0.
